// File: rtl/fold_scheduler.sv
// fold_scheduler: epoch-folding sequencer. Accumulates a sample stream into a phase-binned
// profile in external single-port RAM and streams each sub-integration out while clearing it.
module fold_scheduler #(
   parameter int unsigned NBINS_LOG2 = 10,
   parameter int unsigned SAMPLE_W   = 16,
   parameter int unsigned ACC_W      = 32
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [31:0]           period,
   input  logic [31:0]           epoch,
   input  logic [15:0]           nperiods,
   input  logic                  s_valid,
   input  logic [SAMPLE_W-1:0]   s_data,
   output logic                  s_ready,
   output logic [NBINS_LOG2-1:0] mem_addr,
   output logic                  mem_we,
   output logic [ACC_W-1:0]      mem_wdata,
   input  logic [ACC_W-1:0]      mem_rdata,
   output logic                  m_valid,
   output logic [ACC_W-1:0]      m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  cfg_err,
   output logic [15:0]           subint_count
);
   localparam logic [32:0]           NBINS_EXT = 33'(1) << NBINS_LOG2;
   localparam logic [NBINS_LOG2-1:0] BIN_MAX   = '1;
   localparam logic [NBINS_LOG2-1:0] BIN_ONE   = NBINS_LOG2'(1);

   typedef enum logic [2:0] {IDLE, CLEAR, SKIP, FOLD_RD, FOLD_WR, DUMP_RD, DUMP_OUT} state_t;

   state_t                state_q, state_d;
   logic [31:0]           period_q, period_d, skip_q, skip_d, r_q, r_d;
   logic [15:0]           nper_q, nper_d, pcnt_q, pcnt_d, subint_q, subint_d;
   logic [NBINS_LOG2-1:0] bin_q, bin_d, wbin_q, wbin_d, idx_q, idx_d;
   logic                  wrap_q, wrap_d, stop_pend_q, stop_pend_d, cfg_err_q, cfg_err_d;
   logic [SAMPLE_W-1:0]   sample_q, sample_d;
   logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [ACC_W-1:0]      m_data_q, m_data_d;

   logic                  accept;
   logic [32:0]           r_next;
   logic [ACC_W:0]        samp_ext, sum;

   assign busy         = (state_q != IDLE);
   assign cfg_err      = cfg_err_q;
   assign subint_count = subint_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_last       = m_last_q;

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      skip_d      = skip_q;
      r_d         = r_q;
      nper_d      = nper_q;
      pcnt_d      = pcnt_q;
      subint_d    = subint_q;
      bin_d       = bin_q;
      wbin_d      = wbin_q;
      idx_d       = idx_q;
      wrap_d      = wrap_q;
      cfg_err_d   = cfg_err_q;
      sample_d    = sample_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      m_data_d    = m_data_q;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      stop_pend_d = stop_pend_q | (stop & (state_q != IDLE));
      s_ready     = (state_q == SKIP || state_q == FOLD_RD) && !stop_pend_q;
      accept      = s_valid && s_ready;
      r_next      = {1'b0, r_q} + NBINS_EXT;
      samp_ext    = '0;
      samp_ext[SAMPLE_W-1:0] = sample_q;
      sum         = {1'b0, mem_rdata} + samp_ext;

      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            if (start) begin
               if ({1'b0, period} < NBINS_EXT || nperiods == 16'd0) begin
                  cfg_err_d = 1'b1;
               end else begin
                  cfg_err_d = 1'b0;
                  period_d  = period;
                  nper_d    = nperiods;
                  skip_d    = epoch;
                  r_d       = '0;
                  bin_d     = '0;
                  pcnt_d    = '0;
                  idx_d     = '0;
                  subint_d  = '0;
                  state_d   = CLEAR;
               end
            end
         end
         CLEAR: begin
            if (stop_pend_q) begin
               state_d = IDLE;
            end else begin
               mem_we   = 1'b1;
               mem_addr = idx_q;
               if (idx_q == BIN_MAX) begin
                  idx_d   = '0;
                  state_d = (skip_q != 32'd0) ? SKIP : FOLD_RD;
               end else begin
                  idx_d = idx_q + BIN_ONE;
               end
            end
         end
         SKIP: begin
            if (stop_pend_q) begin
               state_d = IDLE;
            end else if (accept) begin
               skip_d = skip_q - 32'd1;
               if (skip_q == 32'd1) state_d = FOLD_RD;
            end
         end
         FOLD_RD: begin
            mem_addr = bin_q;
            if (stop_pend_q) begin
               state_d = IDLE;
            end else if (accept) begin
               sample_d = s_data;
               wbin_d   = bin_q;
               // Incremental phase: r tracks k*NBINS mod period, so bin = floor(k*NBINS/period).
               if (r_next >= {1'b0, period_q}) begin
                  r_d    = 32'(r_next - {1'b0, period_q});
                  bin_d  = bin_q + BIN_ONE;
                  wrap_d = (bin_q == BIN_MAX);
               end else begin
                  r_d    = r_next[31:0];
                  wrap_d = 1'b0;
               end
               state_d = FOLD_WR;
            end
         end
         FOLD_WR: begin
            mem_addr  = wbin_q;
            mem_we    = 1'b1;
            mem_wdata = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            state_d   = FOLD_RD;
            if (wrap_q) begin
               if (pcnt_q + 16'd1 == nper_q) begin
                  pcnt_d  = '0;
                  state_d = DUMP_RD;
               end else begin
                  pcnt_d = pcnt_q + 16'd1;
               end
            end
         end
         DUMP_RD: begin
            mem_addr = idx_q;
            state_d  = stop_pend_q ? IDLE : DUMP_OUT;
         end
         DUMP_OUT: begin
            mem_addr = idx_q;
            // First cycle captures the read data; m_valid rises once m_data is registered.
            if (!m_valid_q) begin
               m_valid_d = 1'b1;
               m_data_d  = mem_rdata;
               m_last_d  = (idx_q == BIN_MAX);
            end else if (m_ready) begin
               mem_we    = 1'b1;
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (idx_q == BIN_MAX) begin
                  idx_d    = '0;
                  subint_d = subint_q + 16'd1;
                  state_d  = FOLD_RD;
               end else begin
                  idx_d   = idx_q + BIN_ONE;
                  state_d = DUMP_RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         period_q    <= '0;
         skip_q      <= '0;
         r_q         <= '0;
         nper_q      <= '0;
         pcnt_q      <= '0;
         subint_q    <= '0;
         bin_q       <= '0;
         wbin_q      <= '0;
         idx_q       <= '0;
         wrap_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         sample_q    <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         skip_q      <= skip_d;
         r_q         <= r_d;
         nper_q      <= nper_d;
         pcnt_q      <= pcnt_d;
         subint_q    <= subint_d;
         bin_q       <= bin_d;
         wbin_q      <= wbin_d;
         idx_q       <= idx_d;
         wrap_q      <= wrap_d;
         stop_pend_q <= stop_pend_d;
         cfg_err_q   <= cfg_err_d;
         sample_q    <= sample_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_data_q    <= m_data_d;
      end
   end
endmodule

// File: tb/tb_fold_scheduler.sv
// Directed bench for fold_scheduler: two instances with NBINS=8 (32-bit and 16-bit
// accumulators), each backed by a small registered-read RAM.
module tb_fold_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, start, stop, s_valid, m_ready, sel;
   logic [31:0] period, epoch;
   logic [15:0] nperiods, s_data;

   logic        s_ready_a, we_a, m_valid_a, m_last_a, busy_a, cfg_err_a;
   logic [2:0]  addr_a;
   logic [31:0] wdata_a, rdata_a, m_data_a;
   logic [15:0] subint_a;

   logic        s_ready_b, we_b, m_valid_b, m_last_b, busy_b, cfg_err_b;
   logic [2:0]  addr_b;
   logic [15:0] wdata_b, rdata_b, m_data_b, subint_b;

   fold_scheduler #(.NBINS_LOG2(3), .SAMPLE_W(16), .ACC_W(32)) dut_a (
      .clk_in(clk), .rst(rst_a), .start(start), .stop(stop), .period(period), .epoch(epoch),
      .nperiods(nperiods), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
      .mem_addr(addr_a), .mem_we(we_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
      .m_valid(m_valid_a), .m_data(m_data_a), .m_last(m_last_a), .m_ready(m_ready),
      .busy(busy_a), .cfg_err(cfg_err_a), .subint_count(subint_a));

   fold_scheduler #(.NBINS_LOG2(3), .SAMPLE_W(16), .ACC_W(16)) dut_b (
      .clk_in(clk), .rst(rst_b), .start(start), .stop(stop), .period(period), .epoch(epoch),
      .nperiods(nperiods), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
      .mem_addr(addr_b), .mem_we(we_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
      .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b), .m_ready(m_ready),
      .busy(busy_b), .cfg_err(cfg_err_b), .subint_count(subint_b));

   // RAMs hold junk while their DUT is in reset so CLEAR has something to erase.
   logic [31:0] ram_a [8];
   logic [15:0] ram_b [8];
   int unsigned we_cnt = 0;
   always @(posedge clk) begin
      if (rst_a) for (int i = 0; i < 8; i++) ram_a[i] <= 32'hDEAD_0000 + 32'(i);
      else if (we_a) ram_a[addr_a] <= wdata_a;
      if (rst_b) for (int i = 0; i < 8; i++) ram_b[i] <= 16'hBEEF;
      else if (we_b) ram_b[addr_b] <= wdata_b;
      rdata_a <= ram_a[addr_a];
      rdata_b <= ram_b[addr_b];
      if (we_a) we_cnt <= we_cnt + 1;
   end

   logic s_rdy;
   assign s_rdy = sel ? s_ready_b : s_ready_a;

   int unsigned n_vec = 0, n_err = 0;
   int unsigned w0;
   logic [31:0] e1 [8], e2 [8], e3 [8], e4 [8];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [31:0] p, input logic [31:0] e, input logic [15:0] n);
      period = p; epoch = e; nperiods = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
   endtask

   task automatic wait_ready(input string tag);
      int unsigned n;
      n = 0;
      while (!s_rdy && n < 100) begin tick(); n++; end
      if (!s_rdy) chk(tag, s_rdy, 1);
   endtask

   task automatic send_sample(input logic [15:0] v);
      s_data = v; s_valid = 1'b1;
      wait_ready("sample_ready_timeout");
      tick();
      s_valid = 1'b0;
   endtask

   task automatic collect(input logic [31:0] exp [8], input int stall_bin);
      for (int unsigned i = 0; i < 8; i++) begin
         int unsigned n;
         n = 0;
         while (!m_valid_a && n < 100) begin tick(); n++; end
         if (!m_valid_a) chk("dump_valid_timeout", m_valid_a, 1);
         chk("dump_data", m_data_a, exp[i]);
         chk("dump_last", m_last_a, i == 7);
         if (int'(i) == stall_bin) begin
            repeat (10) begin
               tick();
               chk("stall_data", m_data_a, exp[i]);
               chk("stall_s_ready", s_ready_a, 0);
               chk("stall_we", we_a, 0);
            end
         end
         m_ready = 1'b1;
         #1;
         chk("dump_clear_we", we_a, 1);
         chk("dump_clear_addr", addr_a, i);
         tick();
         m_ready = 1'b0;
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      sel = 1'b0; period = '0; epoch = '0; nperiods = '0; s_data = '0;
      for (int i = 0; i < 8; i++) begin
         e1[i] = 32'(i + 1);
         e2[i] = (i % 2 == 0) ? 32'd4 : 32'd2;
         e3[i] = (i % 2 == 0) ? 32'd12 : 32'd6;
         e4[i] = 32'h11 + 32'(i);
      end
      repeat (3) tick();
      rst_a = 1'b0;
      tick();
      chk("rst_s_ready", s_ready_a, 0);
      chk("rst_mem_we", we_a, 0);
      chk("rst_m_valid", m_valid_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_cfg_err", cfg_err_a, 0);
      chk("rst_subint", subint_a, 0);

      // period == NBINS: one sample per bin, then a single dump
      w0 = we_cnt;
      pulse_start(32'd8, 32'd0, 16'd1);
      chk("t1_busy", busy_a, 1);
      wait_ready("t1_clear_timeout");
      chk("t1_clear_writes", we_cnt - w0, 8);
      for (int i = 0; i < 8; i++) send_sample(16'(i + 1));
      collect(e1, -1);
      chk("t1_subint", subint_a, 1);
      chk("t1_back_to_fold", s_ready_a, 1);
      pulse_stop();
      chk("t1_stop_busy", busy_a, 0);
      chk("t1_stop_subint_held", subint_a, 1);

      // period 12: uneven bin occupancy, two periods per sub-integration, stall on bin 3
      pulse_start(32'd12, 32'd0, 16'd2);
      wait_ready("t2_clear_timeout");
      for (int i = 0; i < 24; i++) begin
         send_sample(16'd1);
         if (i == 2) begin
            pulse_start(32'd4, 32'd0, 16'd1);
            chk("t2_start_busy_cfg", cfg_err_a, 0);
            chk("t2_start_busy_busy", busy_a, 1);
         end
      end
      collect(e2, 3);
      for (int i = 0; i < 24; i++) send_sample(16'd3);
      collect(e3, -1);
      chk("t2_subint", subint_a, 2);
      pulse_stop();
      chk("t2_stop_busy", busy_a, 0);

      // period below NBINS is rejected without touching RAM
      pulse_start(32'd4, 32'd0, 16'd1);
      chk("t4_cfg_err", cfg_err_a, 1);
      chk("t4_busy", busy_a, 0);
      w0 = we_cnt;
      repeat (3) tick();
      chk("t4_no_writes", we_cnt - w0, 0);
      chk("t4_still_idle", busy_a, 0);

      // epoch 5: first five samples discarded, sixth lands in bin 0
      pulse_start(32'd8, 32'd5, 16'd1);
      chk("t3_cfg_cleared", cfg_err_a, 0);
      chk("t3_busy", busy_a, 1);
      for (int i = 0; i < 5; i++) send_sample(16'h00AA + 16'(i));
      for (int i = 0; i < 8; i++) send_sample(16'h0011 + 16'(i));
      collect(e4, -1);
      pulse_stop();
      chk("t3_stop_busy", busy_a, 0);
      pulse_start(32'd8, 32'd0, 16'd0);
      chk("t3_nper0_cfg_err", cfg_err_a, 1);
      chk("t3_nper0_busy", busy_a, 0);

      // 16-bit accumulator: saturation, exact full-scale, then async reset in FOLD_WR
      rst_a = 1'b1; sel = 1'b1; rst_b = 1'b0;
      tick();
      pulse_start(32'd16, 32'd0, 16'd1);
      wait_ready("t5_clear_timeout");
      send_sample(16'hFFFF);
      send_sample(16'hFFFF);
      send_sample(16'h8000);
      send_sample(16'h7FFF);
      tick();
      chk("t5_saturated_bin0", ram_b[0], 16'hFFFF);
      chk("t5_fullscale_bin1", ram_b[1], 16'hFFFF);
      send_sample(16'h1234);
      chk("t5_in_fold_wr", we_b, 1);
      rst_b = 1'b1;
      #1;
      chk("t5_rst_outputs", {s_ready_b, we_b, m_valid_b, m_last_b, busy_b, cfg_err_b,
                             subint_b, addr_b, wdata_b, m_data_b}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
